div_issue_ctrl: RTL
===================

# div_issue_ctrl

Initiator-side controller for the 32-iteration DIV/DIVU divider. It sits between the EX stage and the divider. It accepts a divide from EX, latches the operands, and drives the divider's start/annul handshake. While the divide runs it holds the pipeline stalled, then writes the 64-bit result to HI/LO. It also handles pipeline flushes and downstream stalls so the divider never sees a stale or duplicated start.

## Interface
Parameters:
- TIMEOUT, 64, cycles to wait for div_ready_i before aborting (used only with DIV_TIMEOUT_EN).

Ports:
- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  asynchronous, active-low reset.
- ex_div_valid_i  in  1  EX holds a DIV/DIVU instruction.
- ex_op_i  in  6  ALU control code; `DIV_CONTROL` or `DIVU_CONTROL` (alu_defines.vh).
- ex_opdata1_i  in  32  dividend.
- ex_opdata2_i  in  32  divisor.
- flush_i  in  1  pipeline flush/exception; cancels any in-flight divide.
- mem_stall_i  in  1  downstream stall; HI/LO write must be held off while it is high.
- stall_req_o  out  1  stall request to pipeline control.
- busy_o  out  1  controller not in IDLE.
- div_op_o  out  6  op to divider (latched).
- div_opdata1_o, div_opdata2_o  out  32 each  operands to divider (latched).
- div_start_o  out  1  divider start_i.
- div_annul_o  out  1  divider annul_i.
- div_result_i  in  64  divider result; [63:32] remainder, [31:0] quotient.
- div_ready_i  in  1  divider ready_o.
- hilo_we_o  out  1  HI/LO write enable.
- hi_o, lo_o  out  32 each  remainder and quotient to HI/LO.
- div_err_o  out  1  timeout abort pulse (DIV_TIMEOUT_EN only; otherwise tied 0).

## Operation
States: IDLE, ISSUE, DONE, CANCEL.

- **IDLE**
  - Accept when ex_div_valid_i=1 and flush_i=0.
  - On accept: latch op/operands into div_*_o and go to ISSUE.
  - stall_req_o is driven combinationally high in the accept cycle.
- **ISSUE**
  - div_start_o=1; div_annul_o=0; stall_req_o=1.
  - On div_ready_i=1: capture hi_o=div_result_i[63:32] and lo_o=div_result_i[31:0], then go to DONE.
  - Any fixed divider latency is not assumed; the controller waits for ready.
  - flush_i=1 has priority over ready and sends the block to CANCEL.
- **DONE**
  - div_start_o=0, which returns the divider to its free state.
  - hilo_we_o = !flush_i.
  - stall_req_o = mem_stall_i.
  - Exit to IDLE when mem_stall_i=0 or flush_i=1.
  - Repeated writes while mem_stall_i=1 are allowed; they are idempotent.
- **CANCEL**
  - Lasts exactly one cycle: div_start_o=0, div_annul_o=1, stall_req_o=0, then go to IDLE.
  - This guarantees the divider has left its running/end state before any new start.
- The instruction in EX advances on the edge where stall_req_o falls, so IDLE never re-accepts the same instruction.
- Divide by zero: issued to the divider normally; the result {0,0} is written.
- Signed fix-up is done by the divider; this block passes operands unmodified.

## Timing
- Reset (rst=0, asynchronous) clears:
  - state to IDLE;
  - stall_req_o, busy_o, div_start_o, div_annul_o, hilo_we_o, div_err_o to 0;
  - div_op_o, div_opdata*_o, hi_o, lo_o to 0.
- Reset mid-divide: no handshake is required, since the divider shares the reset domain.
- Accept edge to first div_start_o=1: 1 cycle.
- div_ready_i sampled to hilo_we_o=1: 1 cycle.
- Nominal total with the 32-iteration divider: about 36 cycles from accept to HI/LO write.
- flush_i in IDLE: no accept. In ISSUE: CANCEL next cycle. In DONE: no write, go to IDLE.
- div_ready_i outside ISSUE is ignored.

## Configuration
- **DIV_TIMEOUT_EN**
  - Defined: a 7-bit counter runs in ISSUE. If it reaches TIMEOUT without div_ready_i, the block pulses div_err_o for 1 cycle, enters CANCEL, and makes no HI/LO write.
  - Undefined: no counter; ISSUE waits indefinitely and div_err_o=0.

## Test plan
- DIVU 100/7 -> div_start_o held until ready; one hilo_we_o with hi_o=2 and lo_o=14; stall_req_o low on the write cycle.
- DIV -7/2 -> hi_o=0xFFFFFFFF and lo_o=0xFFFFFFFD; DIVU 5/0 -> hi_o=0 and lo_o=0.
- flush_i during ISSUE at cycle 10 -> CANCEL with one cycle of div_annul_o=1; no hilo_we_o; a new DIV accepted the next cycle completes correctly.
- mem_stall_i high for 5 cycles in DONE -> hilo_we_o and stall_req_o stay high; exit on the first cycle with mem_stall_i=0.
- Back-to-back DIVU (20/3 then 9/4) -> two writes, (2,6) then (1,2); start drops between them.
- rst low mid-ISSUE -> all outputs 0 immediately. With DIV_TIMEOUT_EN and div_ready_i held 0 -> div_err_o pulse after 64 cycles, then IDLE.

Source files
------------

// File: rtl/div_issue_ctrl.sv
// div_issue_ctrl: issues DIV/DIVU from EX to the 32-iteration divider,
// stalls the pipeline while it runs and writes the 64-bit result to HI/LO.
// Optional build macro DIV_TIMEOUT_EN adds a TIMEOUT-cycle abort on a divider
// that never signals ready (pulses div_err_o, cancels, no HI/LO write).
`timescale 1ns/1ps
module div_issue_ctrl #(
    parameter int TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ex_div_valid_i,
    input  logic [5:0]  ex_op_i,
    input  logic [31:0] ex_opdata1_i,
    input  logic [31:0] ex_opdata2_i,
    input  logic        flush_i,
    input  logic        mem_stall_i,
    output logic        stall_req_o,
    output logic        busy_o,
    output logic [5:0]  div_op_o,
    output logic [31:0] div_opdata1_o,
    output logic [31:0] div_opdata2_o,
    output logic        div_start_o,
    output logic        div_annul_o,
    input  logic [63:0] div_result_i,
    input  logic        div_ready_i,
    output logic        hilo_we_o,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o,
    output logic        div_err_o
);

    typedef enum logic [1:0] {IDLE, ISSUE, DONE, CANCEL} state_e;

    state_e      state_q, state_d;
    logic [5:0]  op_q, op_d;
    logic [31:0] opd1_q, opd1_d;
    logic [31:0] opd2_q, opd2_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic        accept;
    logic        timeout;

    // The abort counter is 7 bits wide, so TIMEOUT must fit in it.
    if (TIMEOUT < 1 || TIMEOUT > 128) begin : g_bad_timeout
        $error("div_issue_ctrl: TIMEOUT must be in 1..128");
    end

    // A new divide is only taken from IDLE; gating with rst keeps the
    // combinational stall request low while reset is asserted.
    assign accept = rst && (state_q == IDLE) && ex_div_valid_i && !flush_i;

`ifdef DIV_TIMEOUT_EN
    localparam logic [6:0] TIMEOUT_LAST = 7'(TIMEOUT - 1);

    logic [6:0] cnt_q, cnt_d;

    // Count cycles spent in ISSUE; restarts from zero on every entry.
    always_comb begin
        cnt_d = '0;
        if (state_q == ISSUE) begin
            cnt_d = cnt_q + 7'd1;
        end
    end

    // Abort counter register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign timeout = (state_q == ISSUE) && (cnt_q == TIMEOUT_LAST);
`else
    assign timeout = 1'b0;
`endif

    // Next state, latched operands/result and handshake outputs.
    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        opd1_d      = opd1_q;
        opd2_d      = opd2_q;
        hi_d        = hi_q;
        lo_d        = lo_q;
        stall_req_o = 1'b0;
        div_start_o = 1'b0;
        div_annul_o = 1'b0;
        hilo_we_o   = 1'b0;
        div_err_o   = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    op_d        = ex_op_i;
                    opd1_d      = ex_opdata1_i;
                    opd2_d      = ex_opdata2_i;
                    stall_req_o = 1'b1;
                    state_d     = ISSUE;
                end
            end
            ISSUE: begin
                div_start_o = 1'b1;
                stall_req_o = 1'b1;
                // Flush wins over ready; ready wins over the timeout abort.
                if (flush_i) begin
                    state_d = CANCEL;
                end else if (div_ready_i) begin
                    hi_d    = div_result_i[63:32];
                    lo_d    = div_result_i[31:0];
                    state_d = DONE;
                end else if (timeout) begin
                    div_err_o = 1'b1;
                    state_d   = CANCEL;
                end
            end
            DONE: begin
                // Dropping start frees the divider; the write repeats while
                // MEM is stalled, which is harmless.
                hilo_we_o   = !flush_i;
                stall_req_o = mem_stall_i;
                if (!mem_stall_i || flush_i) begin
                    state_d = IDLE;
                end
            end
            CANCEL: begin
                // One annul cycle drives the divider out of run/end state
                // before any new start can be raised.
                div_annul_o = 1'b1;
                state_d     = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, operand and result registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            op_q    <= '0;
            opd1_q  <= '0;
            opd2_q  <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            opd1_q  <= opd1_d;
            opd2_q  <= opd2_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    assign busy_o        = (state_q != IDLE);
    assign div_op_o      = op_q;
    assign div_opdata1_o = opd1_q;
    assign div_opdata2_o = opd2_q;
    assign hi_o          = hi_q;
    assign lo_o          = lo_q;

endmodule
